// File: rtl/wb_axi_pkg.sv
// Shared types, widths and FIFO word packers for the AXI ingress path.
// FIFO words are {fields..., flag} packed MSB-first so egress can unpack them with the same structs.
package wb_axi_pkg;

  localparam int AXI_ID_W    = 3;
  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_LEN_W   = 4;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_LOCK_W  = 2;
  localparam int AXI_CACHE_W = 4;
  localparam int AXI_PROT_W  = 3;
  localparam int AXI_DATA_W  = 32;
  localparam int AXI_STB_W   = 4;

  localparam int FIFO_ADR_W = AXI_ID_W + AXI_ADDR_W + AXI_LEN_W + AXI_SIZE_W + AXI_BURST_W
                            + AXI_LOCK_W + AXI_CACHE_W + AXI_PROT_W + 1;
  localparam int FIFO_DAT_W = AXI_ID_W + AXI_DATA_W + AXI_STB_W + 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_RFILL = 2'd2,
    ST_BRESP = 2'd3
  } state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]    id;
    logic [AXI_ADDR_W-1:0]  addr;
    logic [AXI_LEN_W-1:0]   len;
    logic [AXI_SIZE_W-1:0]  size;
    logic [AXI_BURST_W-1:0] burst;
    logic [AXI_LOCK_W-1:0]  lock;
    logic [AXI_CACHE_W-1:0] cache;
    logic [AXI_PROT_W-1:0]  prot;
    logic                   wr_req;
  } adr_word_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STB_W-1:0]  stb;
    logic                  wlast;
    logic                  wvalid;
  } dat_word_t;

  function automatic logic [FIFO_ADR_W-1:0] pack_adr(
    input logic [AXI_ID_W-1:0]    id,
    input logic [AXI_ADDR_W-1:0]  addr,
    input logic [AXI_LEN_W-1:0]   len,
    input logic [AXI_SIZE_W-1:0]  size,
    input logic [AXI_BURST_W-1:0] burst,
    input logic [AXI_LOCK_W-1:0]  lock,
    input logic [AXI_CACHE_W-1:0] cache,
    input logic [AXI_PROT_W-1:0]  prot,
    input logic                   wr_req
  );
    adr_word_t w;
    w = '{id: id, addr: addr, len: len, size: size, burst: burst,
          lock: lock, cache: cache, prot: prot, wr_req: wr_req};
    return w;
  endfunction

  function automatic logic [FIFO_DAT_W-1:0] pack_dat(
    input logic [AXI_ID_W-1:0]   id,
    input logic [AXI_DATA_W-1:0] data,
    input logic [AXI_STB_W-1:0]  stb,
    input logic                  wlast,
    input logic                  wvalid
  );
    dat_word_t w;
    w = '{id: id, data: data, stb: stb, wlast: wlast, wvalid: wvalid};
    return w;
  endfunction

endpackage

// File: rtl/axi_addr_arb.sv
// Two-way round-robin arbiter between AW and AR; grant is combinational, gated by gnt_en.
// Zero latency; a tie goes to the channel not granted at the previous handshake.
module axi_addr_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic req_w,
  input  logic req_r,
  input  logic gnt_en,
  input  logic advance,
  output logic gnt_w,
  output logic gnt_r
);

  // 1 = write was granted most recently; resets to read so write wins the first tie
  logic last_w_q, last_w_d;

  always_comb begin
    gnt_w    = 1'b0;
    gnt_r    = 1'b0;
    last_w_d = last_w_q;
    if (gnt_en) begin
      if (req_w && (!req_r || !last_w_q)) gnt_w = 1'b1;
      else if (req_r)                     gnt_r = 1'b1;
    end
    if (advance) last_w_d = gnt_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_w_q <= 1'b0;
    else        last_w_q <= last_w_d;
  end

endmodule

// File: rtl/axi_ingress.sv
// AXI3 slave front end: serialises AW/AR into the address FIFO followed by exactly len+1 data entries.
// Handshake to FIFO push is zero-cycle; READYs drop while the target FIFO is full, B is registered.
module axi_ingress
  import wb_axi_pkg::*;
(
  input  logic                   axi_clk,
  input  logic                   axi_resetn,
  input  logic                   ENABLE,
  input  logic [AXI_ID_W-1:0]    AWID,
  input  logic [AXI_ADDR_W-1:0]  AWADDR,
  input  logic [AXI_LEN_W-1:0]   AWLEN,
  input  logic [AXI_SIZE_W-1:0]  AWSIZE,
  input  logic [AXI_BURST_W-1:0] AWBURST,
  input  logic [AXI_LOCK_W-1:0]  AWLOCK,
  input  logic [AXI_CACHE_W-1:0] AWCACHE,
  input  logic [AXI_PROT_W-1:0]  AWPROT,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [AXI_ID_W-1:0]    ARID,
  input  logic [AXI_ADDR_W-1:0]  ARADDR,
  input  logic [AXI_LEN_W-1:0]   ARLEN,
  input  logic [AXI_SIZE_W-1:0]  ARSIZE,
  input  logic [AXI_BURST_W-1:0] ARBURST,
  input  logic [AXI_LOCK_W-1:0]  ARLOCK,
  input  logic [AXI_CACHE_W-1:0] ARCACHE,
  input  logic [AXI_PROT_W-1:0]  ARPROT,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  input  logic [AXI_ID_W-1:0]    WID,
  input  logic [AXI_DATA_W-1:0]  WDATA,
  input  logic [AXI_STB_W-1:0]   WSTRB,
  input  logic                   WLAST,
  input  logic                   WVALID,
  output logic                   WREADY,
  output logic [AXI_ID_W-1:0]    BID,
  output logic [1:0]             BRESP,
  output logic                   BVALID,
  input  logic                   BREADY,
  output logic [FIFO_ADR_W-1:0]  fifo_adr_wdata,
  output logic                   fifo_adr_wr,
  input  logic                   fifo_adr_full,
  output logic [FIFO_DAT_W-1:0]  fifo_dat_wdata,
  output logic                   fifo_dat_wr,
  input  logic                   fifo_dat_full
);

  state_e               state_q, state_d;
  logic [AXI_LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [AXI_ID_W-1:0]  cur_id_q, cur_id_d, bid_q, bid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic                 err_q, err_d, bvalid_q, bvalid_d;
  // Low for the first cycle after reset so no READY is raised while reset is asserted
  logic                 run_q, run_d;
  logic                 gnt_w, gnt_r, gnt_en, adr_hs, wlast_f, beat_err;

  assign gnt_en   = run_q && (state_q == ST_IDLE) && ENABLE && !fifo_adr_full;
  assign AWREADY  = gnt_w;
  assign ARREADY  = gnt_r;
  assign adr_hs   = (gnt_w && AWVALID) || (gnt_r && ARVALID);
  assign WREADY   = (state_q == ST_WDATA) && !fifo_dat_full;
  assign wlast_f  = (beat_cnt_q == '0);
  assign beat_err = (WLAST != wlast_f) || (WID != cur_id_q);
  assign BVALID   = bvalid_q;
  assign BID      = bid_q;
  assign BRESP    = bresp_q;

  axi_addr_arb u_arb (
    .clk     (axi_clk),
    .rst_n   (axi_resetn),
    .req_w   (AWVALID),
    .req_r   (ARVALID),
    .gnt_en  (gnt_en),
    .advance (adr_hs),
    .gnt_w   (gnt_w),
    .gnt_r   (gnt_r)
  );

  always_comb begin
    state_d        = state_q;
    beat_cnt_d     = beat_cnt_q;
    cur_id_d       = cur_id_q;
    err_d          = err_q;
    bvalid_d       = bvalid_q;
    bid_d          = bid_q;
    bresp_d        = bresp_q;
    run_d          = 1'b1;
    fifo_adr_wr    = 1'b0;
    fifo_adr_wdata = '0;
    fifo_dat_wr    = 1'b0;
    fifo_dat_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_w && AWVALID) begin
          fifo_adr_wr    = 1'b1;
          fifo_adr_wdata = pack_adr(AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, 1'b1);
          cur_id_d       = AWID;
          beat_cnt_d     = AWLEN;
          err_d          = 1'b0;
          state_d        = ST_WDATA;
        end else if (gnt_r && ARVALID) begin
          fifo_adr_wr    = 1'b1;
          fifo_adr_wdata = pack_adr(ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, 1'b0);
          cur_id_d       = ARID;
          beat_cnt_d     = ARLEN;
          err_d          = 1'b0;
          state_d        = ST_RFILL;
        end
      end
      ST_WDATA: begin
        if (WVALID && WREADY) begin
          // The beat counter, not the master's WLAST, decides where the burst ends
          fifo_dat_wr    = 1'b1;
          fifo_dat_wdata = pack_dat(WID, WDATA, WSTRB, wlast_f, 1'b1);
          err_d          = err_q || beat_err;
          beat_cnt_d     = beat_cnt_q - 1'b1;
          if (wlast_f) begin
            state_d  = ST_BRESP;
            bvalid_d = 1'b1;
            bid_d    = cur_id_q;
            bresp_d  = (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      ST_RFILL: begin
        if (!fifo_dat_full) begin
          fifo_dat_wr    = 1'b1;
          fifo_dat_wdata = pack_dat(cur_id_q, '0, '0, wlast_f, 1'b0);
          beat_cnt_d     = beat_cnt_q - 1'b1;
          if (wlast_f) state_d = ST_IDLE;
        end
      end
      ST_BRESP: begin
        if (BREADY) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      cur_id_q   <= '0;
      err_q      <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      cur_id_q   <= cur_id_d;
      err_q      <= err_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      run_q      <= run_d;
    end
  end

endmodule

// File: tb/tb_axi_ingress.sv
// Directed bench for axi_ingress: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_axi_ingress;

  logic        axi_clk, axi_resetn, ENABLE;
  logic [2:0]  AWID, ARID, WID, BID;
  logic [31:0] AWADDR, ARADDR, WDATA;
  logic [3:0]  AWLEN, ARLEN, AWCACHE, ARCACHE, WSTRB;
  logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
  logic [1:0]  AWBURST, ARBURST, AWLOCK, ARLOCK, BRESP;
  logic        AWVALID, AWREADY, ARVALID, ARREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic [53:0] fifo_adr_wdata;
  logic [40:0] fifo_dat_wdata;
  logic        fifo_adr_wr, fifo_adr_full, fifo_dat_wr, fifo_dat_full;

  axi_ingress dut (
    .axi_clk(axi_clk), .axi_resetn(axi_resetn), .ENABLE(ENABLE),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .fifo_adr_wdata(fifo_adr_wdata), .fifo_adr_wr(fifo_adr_wr), .fifo_adr_full(fifo_adr_full),
    .fifo_dat_wdata(fifo_dat_wdata), .fifo_dat_wr(fifo_dat_wr), .fifo_dat_full(fifo_dat_full)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected FIFO words, built field by field in the documented order
  function automatic logic [53:0] e_adr(input logic [2:0] id, input logic [31:0] a,
                                        input logic [3:0] len, input logic wr);
    return {id, a, len, 3'd2, 2'd1, 2'b00, 4'b0000, 3'b000, wr};
  endfunction

  function automatic logic [40:0] e_dat(input logic [2:0] id, input logic [31:0] d,
                                        input logic [3:0] stb, input logic last, input logic v);
    return {id, d, stb, last, v};
  endfunction

  // Pushes are recorded mid-low-phase, after inputs driven at the falling edge have settled
  logic [53:0] adr_log[$];
  logic [40:0] dat_log[$];
  always @(negedge axi_clk) begin
    #2;
    if (fifo_adr_wr) adr_log.push_back(fifo_adr_wdata);
    if (fifo_dat_wr) dat_log.push_back(fifo_dat_wdata);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic [3:0] in_v;   // {AWVALID, ARVALID, WVALID, WLAST}
    logic [7:0] wd;
    logic [1:0] in_b;   // {BREADY, fifo_dat_full}
    logic [5:0] ex;     // {AWREADY, ARREADY, WREADY, fifo_adr_wr, fifo_dat_wr, BVALID}
    logic [1:0] ex_resp;
    logic [2:0] ex_bid;
  } vec_t;

  vec_t vt[13];
  int   n, cyc, idx;

  initial begin
    vt[0]  = '{4'b1000, 8'h00, 2'b00, 6'b100100, 2'b00, 3'd0};
    vt[1]  = '{4'b0010, 8'hA0, 2'b00, 6'b001010, 2'b00, 3'd0};
    vt[2]  = '{4'b0010, 8'hA1, 2'b00, 6'b001010, 2'b00, 3'd0};
    vt[3]  = '{4'b0000, 8'h00, 2'b00, 6'b001000, 2'b00, 3'd0};
    vt[4]  = '{4'b0010, 8'hA2, 2'b00, 6'b001010, 2'b00, 3'd0};
    vt[5]  = '{4'b0011, 8'hA3, 2'b00, 6'b001010, 2'b00, 3'd0};
    vt[6]  = '{4'b0000, 8'h00, 2'b00, 6'b000001, 2'b00, 3'd2};
    vt[7]  = '{4'b0000, 8'h00, 2'b10, 6'b000001, 2'b00, 3'd2};
    vt[8]  = '{4'b0100, 8'h00, 2'b00, 6'b010100, 2'b00, 3'd2};
    vt[9]  = '{4'b0000, 8'h00, 2'b01, 6'b000000, 2'b00, 3'd2};
    vt[10] = '{4'b0000, 8'h00, 2'b00, 6'b000010, 2'b00, 3'd2};
    vt[11] = '{4'b0000, 8'h00, 2'b00, 6'b000010, 2'b00, 3'd2};
    vt[12] = '{4'b0000, 8'h00, 2'b00, 6'b000000, 2'b00, 3'd2};

    axi_resetn = 1'b1; ENABLE = 1'b1;
    AWID = 3'd2; AWADDR = 32'h1000; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'd1;
    AWLOCK = 2'b00; AWCACHE = 4'b0000; AWPROT = 3'b000; AWVALID = 1'b1;
    ARID = 3'd5; ARADDR = 32'h2000; ARLEN = 4'd1; ARSIZE = 3'd2; ARBURST = 2'd1;
    ARLOCK = 2'b00; ARCACHE = 4'b0000; ARPROT = 3'b000; ARVALID = 1'b0;
    WID = 3'd2; WDATA = 32'h0; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    fifo_adr_full = 1'b0; fifo_dat_full = 1'b0;
    #1 axi_resetn = 1'b0;

    // Reset state, with AWVALID and ENABLE already high
    @(negedge axi_clk); #1;
    chk("reset_ctrl", 64'({AWREADY, ARREADY, WREADY, BVALID, BRESP, BID, fifo_adr_wr, fifo_dat_wr}), 64'd0);
    chk("reset_wdata", 64'({fifo_adr_wdata, 10'd0} | 64'(fifo_dat_wdata)), 64'd0);
    @(negedge axi_clk);
    axi_resetn = 1'b1; AWVALID = 1'b0;

    // Write len=3 then read len=1, cycle by cycle
    for (int i = 0; i < 13; i++) begin
      @(negedge axi_clk);
      {AWVALID, ARVALID, WVALID, WLAST} = vt[i].in_v;
      WDATA = {24'h0, vt[i].wd};
      {BREADY, fifo_dat_full} = vt[i].in_b;
      #1;
      chk($sformatf("vec[%0d]", i),
          64'({AWREADY, ARREADY, WREADY, fifo_adr_wr, fifo_dat_wr, BVALID, BRESP, BID}),
          64'({vt[i].ex, vt[i].ex_resp, vt[i].ex_bid}));
    end
    chk("t1_adr_cnt", 64'(adr_log.size()), 64'd2);
    chk("t1_dat_cnt", 64'(dat_log.size()), 64'd6);
    if (adr_log.size() == 2 && dat_log.size() == 6) begin
      chk("t1_adr_w", 64'(adr_log[0]), 64'(e_adr(3'd2, 32'h1000, 4'd3, 1'b1)));
      chk("t1_adr_r", 64'(adr_log[1]), 64'(e_adr(3'd5, 32'h2000, 4'd1, 1'b0)));
      for (int k = 0; k < 4; k++)
        chk($sformatf("t1_wbeat%0d", k), 64'(dat_log[k]),
            64'(e_dat(3'd2, 32'hA0 + 32'(k), 4'hF, k == 3, 1'b1)));
      chk("t1_rfill0", 64'(dat_log[4]), 64'(e_dat(3'd5, 32'h0, 4'h0, 1'b0, 1'b0)));
      chk("t1_rfill1", 64'(dat_log[5]), 64'(e_dat(3'd5, 32'h0, 4'h0, 1'b1, 1'b0)));
    end

    // Both address channels held with len=0: W, R, W, R
    adr_log.delete(); dat_log.delete();
    AWLEN = 4'd0; ARLEN = 4'd0;
    @(negedge axi_clk);
    AWVALID = 1'b1; ARVALID = 1'b1; WVALID = 1'b1; WLAST = 1'b1; BREADY = 1'b1; WDATA = 32'hC0;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 40) begin
      #1;
      if (fifo_adr_wr) n++;
      cyc++;
      @(negedge axi_clk);
      if (n == 4) begin AWVALID = 1'b0; ARVALID = 1'b0; end
    end
    repeat (3) @(negedge axi_clk);
    WVALID = 1'b0; BREADY = 1'b0;
    chk("alt_grants", 64'(n), 64'd4);
    chk("alt_adr_cnt", 64'(adr_log.size()), 64'd4);
    chk("alt_dat_cnt", 64'(dat_log.size()), 64'd4);
    if (adr_log.size() == 4 && dat_log.size() == 4)
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("alt_adr%0d", k), 64'(adr_log[k]), (k % 2 == 0) ?
            64'(e_adr(3'd2, 32'h1000, 4'd0, 1'b1)) : 64'(e_adr(3'd5, 32'h2000, 4'd0, 1'b0)));
        chk($sformatf("alt_dat%0d", k), 64'(dat_log[k]), (k % 2 == 0) ?
            64'(e_dat(3'd2, 32'hC0, 4'hF, 1'b1, 1'b1)) : 64'(e_dat(3'd5, 32'h0, 4'h0, 1'b1, 1'b0)));
      end

    // Data FIFO full for 5 cycles in the middle of a len=7 write
    adr_log.delete(); dat_log.delete();
    AWLEN = 4'd7;
    @(negedge axi_clk); AWVALID = 1'b1; #1;
    chk("stall_awready", 64'(AWREADY), 64'd1);
    @(negedge axi_clk); AWVALID = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 8 && cyc < 40) begin
      WVALID = 1'b1; WDATA = 32'hB0 + 32'(idx); WLAST = (idx == 7);
      fifo_dat_full = (cyc >= 2 && cyc < 7);
      #1;
      if (fifo_dat_full) chk($sformatf("stall_wready_c%0d", cyc), 64'(WREADY), 64'd0);
      if (WREADY) idx++;
      cyc++;
      @(negedge axi_clk);
    end
    WVALID = 1'b0; fifo_dat_full = 1'b0;
    chk("stall_beats", 64'(idx), 64'd8);
    chk("stall_dat_cnt", 64'(dat_log.size()), 64'd8);
    if (dat_log.size() == 8)
      for (int k = 0; k < 8; k++)
        chk($sformatf("stall_beat%0d", k), 64'(dat_log[k]),
            64'(e_dat(3'd2, 32'hB0 + 32'(k), 4'hF, k == 7, 1'b1)));
    #1;
    chk("stall_b", 64'({BVALID, BRESP, BID}), 64'({1'b1, 2'b00, 3'd2}));
    @(negedge axi_clk); BREADY = 1'b1;
    @(negedge axi_clk); BREADY = 1'b0;

    // Early WLAST on a len=2 write: counter still closes the burst, response is SLVERR
    dat_log.delete();
    AWLEN = 4'd2;
    @(negedge axi_clk); AWVALID = 1'b1;
    @(negedge axi_clk); AWVALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      WVALID = 1'b1; WLAST = (k == 1); WDATA = 32'hD0 + 32'(k);
      @(negedge axi_clk);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    #1;
    chk("badlast_b", 64'({BVALID, BRESP, BID}), 64'({1'b1, 2'b10, 3'd2}));
    chk("badlast_cnt", 64'(dat_log.size()), 64'd3);
    if (dat_log.size() == 3)
      chk("badlast_flags", 64'({dat_log[0][1], dat_log[1][1], dat_log[2][1]}), 64'(3'b001));
    @(negedge axi_clk); BREADY = 1'b1;
    @(negedge axi_clk); BREADY = 1'b0;

    // Reset in the middle of a write burst, then ENABLE gating
    dat_log.delete(); adr_log.delete();
    AWLEN = 4'd3;
    @(negedge axi_clk); AWVALID = 1'b1;
    @(negedge axi_clk); AWVALID = 1'b0; WVALID = 1'b1; WDATA = 32'hE0;
    @(negedge axi_clk);
    axi_resetn = 1'b0; ENABLE = 1'b0; AWVALID = 1'b1;
    #1;
    chk("midrst_ctrl", 64'({AWREADY, ARREADY, WREADY, BVALID, BRESP, BID, fifo_adr_wr, fifo_dat_wr}), 64'd0);
    chk("midrst_wdata", 64'({fifo_adr_wdata, 10'd0} | 64'(fifo_dat_wdata)), 64'd0);
    @(negedge axi_clk); axi_resetn = 1'b1; WVALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge axi_clk); #1;
      chk($sformatf("dis_awready%0d", k), 64'({AWREADY, WREADY, fifo_adr_wr}), 64'd0);
    end
    @(negedge axi_clk); ENABLE = 1'b1; #1;
    chk("en_awready", 64'({AWREADY, fifo_adr_wr}), 64'(2'b11));
    chk("midrst_dat_cnt", 64'(dat_log.size()), 64'd1);
    chk("midrst_adr_cnt", 64'(adr_log.size()), 64'd1);
    @(negedge axi_clk); AWVALID = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
